// File: rtl/ps2_rx_ctrl_pkg.sv
// Shared PS/2 receive definitions: frame sequencer states,
// data width and the odd-parity rule used on the wire.
package ps2_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS = 8;
    localparam logic [2:0] PS2_LAST_BIT = 3'(PS2_DATA_BITS - 1);

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_ctrl_debouncer.sv
// Line filter: output follows the input only after it has
// differed from the output for 2^N consecutive clocks.
module ps2_rx_ctrl_debouncer #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    logic         raw_q;
    logic [N-1:0] cnt;

    // Register the raw line, then count how long it disagrees with the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            raw_q <= raw;
            if (raw_q == clean) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                clean <= raw_q;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: filters the lines, sequences the
// 11-bit frame and presents good bytes on a valid/ready port.
module ps2_rx_ctrl
    import ps2_rx_ctrl_pkg::*;
#(
    parameter int DEB_N   = 3,
    parameter int TIMEOUT = 100000,
    parameter int TO_W    = 17
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_err_parity,
    output logic       o_err_frame,
    output logic       o_overrun,
    input  logic       i_clr_err
);

    logic s_clk;
    logic s_data;
    logic clk_q;
    logic fall;
    logic expire;

    ps2_state_t      state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] cnt_q;
    logic            perr_d, ferr_d, good_d;
    logic            load;

    ps2_rx_ctrl_debouncer #(.N(DEB_N)) u_deb_clk (
        .clk   (i_clk),
        .rst   (i_rst),
        .raw   (i_ps2_clk),
        .clean (s_clk)
    );

    ps2_rx_ctrl_debouncer #(.N(DEB_N)) u_deb_data (
        .clk   (i_clk),
        .rst   (i_rst),
        .raw   (i_ps2_data),
        .clean (s_data)
    );

    assign fall   = clk_q & ~s_clk;
    assign expire = (state_q != ST_IDLE) && (cnt_q == TO_W'(TIMEOUT - 1));
    assign o_busy = (state_q != ST_IDLE);
    assign load   = good_d && (!o_valid || i_ready);

    // Delayed filtered clock for falling-edge detection; resets low so the
    // filter's power-up rise never looks like an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) clk_q <= 1'b0;
        else       clk_q <= s_clk;
    end

    // Inter-edge watchdog: idle and every falling edge restart it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                         cnt_q <= '0;
        else if (state_q == ST_IDLE || fall) cnt_q <= '0;
        else                               cnt_q <= cnt_q + 1'b1;
    end

    // Frame sequencer state and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
        end
    end

    // Next-state logic; a falling edge always takes priority over expiry.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        good_d   = 1'b0;
        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!s_data) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d  = {s_data, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == PS2_LAST_BIT) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = s_data;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!s_data)                            ferr_d = 1'b1;
                    else if (!ps2_parity_ok(shift_q, par_q)) perr_d = 1'b1;
                    else                                    good_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (expire) begin
            state_d  = ST_IDLE;
            shift_d  = '0;
            bitcnt_d = '0;
            ferr_d   = 1'b1;
        end
    end

    // Error pulses last exactly one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err_parity <= 1'b0;
            o_err_frame  <= 1'b0;
        end else begin
            o_err_parity <= perr_d;
            o_err_frame  <= ferr_d;
        end
    end

    // Output byte register with valid/ready handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (load) begin
            o_data  <= shift_q;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a clear request beats a same-cycle drop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                   o_overrun <= 1'b0;
        else if (i_clr_err)          o_overrun <= 1'b0;
        else if (good_d && !load)    o_overrun <= 1'b1;
    end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed fault scenarios
// plus randomized frames compared against a frame-level model.
module tb_ps2_rx_ctrl;

    localparam int DEB_N   = 3;
    localparam int TIMEOUT = 300;
    localparam int TO_W    = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready = 1'b1;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       err_parity;
    logic       err_frame;
    logic       overrun;

    int n_chk = 0;
    int n_err = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_both = 0;
    int half = 30;
    logic [7:0] rx_q[$];

    ps2_rx_ctrl #(.DEB_N(DEB_N), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_busy       (busy),
        .o_err_parity (err_parity),
        .o_err_frame  (err_frame),
        .o_overrun    (overrun),
        .i_clr_err    (clr_err)
    );

    always #10 clk = ~clk;

    // Consumer side: record accepted bytes and count error-pulse cycles.
    always @(negedge clk) begin
        if (valid && ready) rx_q.push_back(data);
        if (err_parity) n_perr++;
        if (err_frame) n_ferr++;
        if (err_parity && err_frame) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Device drives data while the clock is high; host samples at the fall.
    task automatic send_bits(input logic [10:0] bits, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ps2_data = bits[i];
            tick(half);
            ps2_clk = 1'b0;
            tick(half);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    // Frame outcome: 0 good byte, 1 parity fault, 2 framing fault.
    function automatic int classify(input logic [7:0] b, input logic p, input logic s);
        if (!s) return 2;
        if ((($countones(b) + int'(p)) % 2) != 1) return 1;
        return 0;
    endfunction

    task automatic run_frame(input logic [7:0] b, input logic p, input logic s,
                             input string tag);
        int r0, pe0, fe0, c;
        r0  = rx_q.size();
        pe0 = n_perr;
        fe0 = n_ferr;
        send_bits(mk(b, p, s), 0, 10);
        ps2_data = 1'b1;
        tick(4 * half);
        c = classify(b, p, s);
        chk({tag, ".rx_count"}, rx_q.size() - r0, (c == 0) ? 1 : 0);
        if (c == 0 && rx_q.size() > r0) chk({tag, ".byte"}, rx_q[$], b);
        chk({tag, ".perr"}, n_perr - pe0, (c == 1) ? 1 : 0);
        chk({tag, ".ferr"}, n_ferr - fe0, (c == 2) ? 1 : 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".valid"}, valid, 0);
    endtask

    initial begin
        int r0, pe0, fe0;
        logic [7:0] b;
        logic p, s;

        tick(5);
        chk("rst.valid", valid, 0);
        chk("rst.busy", busy, 0);
        rst = 1'b0;
        tick(50);
        chk("idle.valid", valid, 0);
        chk("idle.data", data, 0);
        chk("idle.busy", busy, 0);
        chk("idle.overrun", overrun, 0);
        chk("idle.ferr", n_ferr, 0);

        run_frame(8'h1C, 1'b0, 1'b1, "good_1c");
        run_frame(8'h1C, 1'b1, 1'b1, "par_1c");
        run_frame(8'hF0, 1'b1, 1'b0, "stop_f0");

        ready = 1'b0;
        r0 = rx_q.size();
        pe0 = n_perr;
        fe0 = n_ferr;
        send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10);
        ps2_data = 1'b1;
        tick(4 * half);
        chk("ovr.valid1", valid, 1);
        chk("ovr.data1", data, 8'h1C);
        chk("ovr.flag0", overrun, 0);
        send_bits(mk(8'h32, 1'b0, 1'b1), 0, 10);
        ps2_data = 1'b1;
        tick(4 * half);
        chk("ovr.data_hold", data, 8'h1C);
        chk("ovr.valid_hold", valid, 1);
        chk("ovr.flag", overrun, 1);
        chk("ovr.no_err", (n_perr - pe0) + (n_ferr - fe0), 0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
        chk("ovr.clr", overrun, 0);
        chk("ovr.valid_after_clr", valid, 1);
        ready = 1'b1;
        tick(3);
        chk("ovr.accept_cnt", rx_q.size() - r0, 1);
        if (rx_q.size() > r0) chk("ovr.accept_byte", rx_q[$], 8'h1C);
        chk("ovr.valid_drop", valid, 0);

        r0 = rx_q.size();
        fe0 = n_ferr;
        send_bits(mk(8'h45, 1'b1, 1'b1), 0, 4);
        ps2_data = 1'b1;
        tick(5);
        chk("to.busy_mid", busy, 1);
        tick(TIMEOUT + 100);
        chk("to.ferr", n_ferr - fe0, 1);
        chk("to.busy", busy, 0);
        chk("to.rx", rx_q.size() - r0, 0);
        run_frame(8'h45, 1'b0, 1'b1, "after_to_45");

        ready = 1'b0;
        send_bits(mk(8'h5A, 1'b1, 1'b1), 0, 10);
        ps2_data = 1'b1;
        tick(4 * half);
        chk("rstmid.pre_valid", valid, 1);
        r0 = rx_q.size();
        pe0 = n_perr;
        fe0 = n_ferr;
        send_bits(mk(8'h29, 1'b0, 1'b1), 0, 6);
        chk("rstmid.busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("rstmid.valid", valid, 0);
        chk("rstmid.data", data, 0);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.errs", {err_parity, err_frame, overrun}, 0);
        ready = 1'b1;
        send_bits(mk(8'h29, 1'b0, 1'b1), 7, 10);
        ps2_data = 1'b1;
        tick(20);
        rst = 1'b0;
        tick(4 * half);
        chk("rstmid.no_byte", rx_q.size() - r0, 0);
        chk("rstmid.no_err", (n_perr - pe0) + (n_ferr - fe0), 0);
        chk("rstmid.valid_after", valid, 0);
        run_frame(8'h29, 1'b0, 1'b1, "after_rst_29");

        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom);
            p = ($urandom_range(0, 4) == 0) ? ^b : ~^b;
            s = ($urandom_range(0, 9) != 0);
            half = $urandom_range(25, 35);
            run_frame(b, p, s, $sformatf("rnd%0d", k));
            tick($urandom_range(0, 40));
        end

        chk("no_dual_pulse", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
